dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port, word-indexed 64-entry data memory between two requesters: the core load/store path (port c_*) and a debug/loader host (port h_*).
- Arbitrates with round-robin priority and an optional host bus lock, bounded by a starvation limit.
- Checks address range and alignment on every granted request.
- Sits between the core datapath and the data memory; the core stalls on c_stall.

Parameters:
- IDX_W, 6: memory index width (depth = 2**IDX_W words).
- MAX_LOCK, 16: maximum consecutive locked host grants before the lock is forcibly dropped.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset, sampled on posedge clk.
- c_req  in  1  core request; held until granted.
- c_we  in  1  core write (1) / read (0).
- c_addr  in  32  core byte address.
- c_wdata  in  32  core write data.
- c_gnt  out  1  core granted this cycle (combinational).
- c_stall  out  1  c_req & ~c_gnt.
- c_rvalid  out  1  core read data valid; one cycle after a granted read.
- c_rdata  out  32  core read data.
- c_err  out  1  qualifies c_rvalid, or pulses one cycle after a granted write, on a bad address.
- h_req, h_we, h_addr, h_wdata, h_gnt, h_rvalid, h_rdata, h_err: same as the c_* ports, for the host.
- h_lock  in  1  host requests that the bus stay with the host after this grant.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_idx  out  IDX_W  word index, taken from addr[IDX_W+1:2].
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset, while rst=1 and on the cycle after:
  - c_gnt, h_gnt, mem_en, mem_we = 0.
  - c_rvalid, h_rvalid, c_err, h_err = 0; rdata outputs = 0.
  - last_q=HOST, so the core wins the first tie; lock_q=0; lock_cnt=0; pending read flags cleared.
- Reset mid-operation: an in-flight read is dropped and no rvalid is issued; an active lock is released.
- Grant is combinational and at most one grant per cycle:
  - lock_q=1: the host is granted if h_req; the core is never granted.
  - lock_q=0 and only one requester: that requester is granted.
  - lock_q=0 and both request: the requester opposite to last_q is granted.
- last_q updates to the winner on every grant.
- Bad address: addr[31:IDX_W+2] != 0, or addr[1:0] != 0.
  - Good address: the grant drives mem_en=1, mem_we=we, mem_idx, mem_wdata in the same cycle.
  - Bad address: the request is granted but mem_en=0, and memory is untouched.
- Read completion: the cycle after a granted read, the requester sees rvalid=1.
  - rdata = mem_rdata if the address was good; rdata = 0 and err=1 if it was bad.
- Write completion: the write takes effect at the grant edge; there is no rvalid. err pulses the next cycle if the address was bad.
- Back-to-back: a new grant is allowed every cycle, including a read immediately followed by another read (rvalid pipelined).
- Lock:
  - Set: lock_q set at a host grant with h_lock=1.
  - Cleared on any cycle with h_lock=0 or h_req=0.
  - lock_cnt counts locked host grants and saturates at MAX_LOCK.
  - When lock_cnt reaches MAX_LOCK: lock_q clears and force_c is set for one arbitration.
  - While force_c=1 and c_req=1: the core wins the next contested cycle, then force_c clears. lock_cnt resets to 0 when the lock clears.
- c_stall = c_req & ~c_gnt; it is 0 when c_req=0.
- Inputs are ignored when req=0.

Decomposition:
- Shared package (dmem_arb_pkg):
  - requester encoding CORE=0, HOST=1;
  - address-check localparams;
  - default IDX_W.
- One natural sub-module, dmem_rr_grant: combinational 2-way grant from (c_req, h_req, last_q, lock_q, force_c).
- Pending-read, lock and error pipeline registers live in the top.

Test Plan:
- Reset, then c_req read addr 0x08 with mem[2]=0xDEADBEEF: c_gnt=1 same cycle, mem_idx=2, next cycle c_rvalid=1, c_rdata=0xDEADBEEF.
- Both requesters held for 4 cycles after reset: grant order CORE, HOST, CORE, HOST; c_stall=1 on cycles 2 and 4.
- Host holds h_lock=1, h_req=1, with c_req=1 and MAX_LOCK=4: 4 host grants, then 1 core grant, then host again.
- h_addr=0x102 (misaligned) write: h_gnt=1, mem_en=0, h_err=1 next cycle; c_addr=0x100 (out of range) read: c_rvalid=1, c_err=1, c_rdata=0.
- Core read granted, rst asserted on the following edge: no c_rvalid; all outputs 0 on the cycle after; lock_q=0.
- Core write 0x55 to 0x04 then core read 0x04 on the next cycle: c_rdata=0x55 one cycle after the read grant; c_stall=0 throughout.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and address-check helpers for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_HOST = 1'b1
    } req_e;

    localparam int DEF_IDX_W  = 6;
    localparam int WORD_BYTES = 4;
    localparam int ALIGN_W    = 2;

    // Good address: word aligned and no bits set above the memory index.
    function automatic logic addr_ok(input logic [31:0] addr, input int idx_w);
        return (addr[ALIGN_W-1:0] == '0) && ((addr >> (idx_w + ALIGN_W)) == 32'd0);
    endfunction

endpackage

// File: rtl/dmem_rr_grant.sv
// Combinational two-way grant: host lock first, then forced core turn, then round robin.
// Zero latency; at most one grant asserted per cycle.
module dmem_rr_grant
    import dmem_arb_pkg::*;
(
    input  logic c_req,
    input  logic h_req,
    input  req_e last_q,
    input  logic lock_q,
    input  logic force_c,
    output logic c_gnt,
    output logic h_gnt
);

    always_comb begin
        c_gnt = 1'b0;
        h_gnt = 1'b0;
        if (lock_q) begin
            h_gnt = h_req;
        end else if (c_req && h_req) begin
            if (force_c || (last_q == REQ_HOST)) begin
                c_gnt = 1'b1;
            end else begin
                h_gnt = 1'b1;
            end
        end else begin
            c_gnt = c_req;
            h_gnt = h_req;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between the core and a debug host.
// Grant is same-cycle; read data returns one cycle later; losers stall until granted.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int IDX_W    = DEF_IDX_W,
    parameter int MAX_LOCK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_req,
    input  logic             c_we,
    input  logic [31:0]      c_addr,
    input  logic [31:0]      c_wdata,
    output logic             c_gnt,
    output logic             c_stall,
    output logic             c_rvalid,
    output logic [31:0]      c_rdata,
    output logic             c_err,
    input  logic             h_req,
    input  logic             h_we,
    input  logic [31:0]      h_addr,
    input  logic [31:0]      h_wdata,
    input  logic             h_lock,
    output logic             h_gnt,
    output logic             h_rvalid,
    output logic [31:0]      h_rdata,
    output logic             h_err,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_idx,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    req_e             last_q, last_d;
    logic             lock_q, lock_d;
    logic             force_q, force_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             c_rd_q, c_rd_d, h_rd_q, h_rd_d;
    logic             c_bad_q, c_bad_d, h_bad_q, h_bad_d;
    logic             rst_dly_q;

    logic        quiet, c_req_eff, h_req_eff, gnt_any, sel_we, sel_ok;
    logic [31:0] sel_addr, sel_wdata;

    // Requests are masked during reset and the one cycle after it.
    assign quiet     = rst | rst_dly_q;
    assign c_req_eff = c_req & ~quiet;
    assign h_req_eff = h_req & ~quiet;

    dmem_rr_grant u_grant (
        .c_req   (c_req_eff),
        .h_req   (h_req_eff),
        .last_q  (last_q),
        .lock_q  (lock_q),
        .force_c (force_q),
        .c_gnt   (c_gnt),
        .h_gnt   (h_gnt)
    );

    assign gnt_any   = c_gnt | h_gnt;
    assign sel_we    = h_gnt ? h_we    : c_we;
    assign sel_addr  = h_gnt ? h_addr  : c_addr;
    assign sel_wdata = h_gnt ? h_wdata : c_wdata;
    assign sel_ok    = addr_ok(sel_addr, IDX_W);

    assign mem_en    = gnt_any & sel_ok;
    assign mem_we    = mem_en & sel_we;
    assign mem_idx   = sel_addr[IDX_W+1:2];
    assign mem_wdata = sel_wdata;

    assign c_stall  = c_req & ~c_gnt;
    assign c_rvalid = c_rd_q & ~rst;
    assign h_rvalid = h_rd_q & ~rst;
    assign c_err    = c_bad_q & ~rst;
    assign h_err    = h_bad_q & ~rst;
    assign c_rdata  = (c_rvalid && !c_bad_q) ? mem_rdata : 32'd0;
    assign h_rdata  = (h_rvalid && !h_bad_q) ? mem_rdata : 32'd0;

    always_comb begin
        c_rd_d     = c_gnt & ~c_we;
        h_rd_d     = h_gnt & ~h_we;
        c_bad_d    = c_gnt & ~sel_ok;
        h_bad_d    = h_gnt & ~sel_ok;
        last_d     = last_q;
        lock_d     = lock_q;
        lock_cnt_d = lock_cnt_q;
        force_d    = force_q;

        if (c_gnt) last_d = REQ_CORE;
        if (h_gnt) last_d = REQ_HOST;

        // The forced core turn is spent once the core wins or stops asking.
        if (force_q && (c_gnt || !c_req_eff)) force_d = 1'b0;

        if (!h_req_eff || !h_lock) begin
            lock_d     = 1'b0;
            lock_cnt_d = '0;
        end else if (h_gnt) begin
            if (lock_cnt_q == CNT_W'(MAX_LOCK - 1)) begin
                lock_d     = 1'b0;
                lock_cnt_d = '0;
                force_d    = 1'b1;
            end else begin
                lock_d     = 1'b1;
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= REQ_HOST;
            lock_q     <= 1'b0;
            force_q    <= 1'b0;
            lock_cnt_q <= '0;
            c_rd_q     <= 1'b0;
            h_rd_q     <= 1'b0;
            c_bad_q    <= 1'b0;
            h_bad_q    <= 1'b0;
            rst_dly_q  <= 1'b1;
        end else begin
            last_q     <= last_d;
            lock_q     <= lock_d;
            force_q    <= force_d;
            lock_cnt_q <= lock_cnt_d;
            c_rd_q     <= c_rd_d;
            h_rd_q     <= h_rd_d;
            c_bad_q    <= c_bad_d;
            h_bad_q    <= h_bad_d;
            rst_dly_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small behavioural memory behind it.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, c_gnt, c_stall, c_rvalid, c_err;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        h_req, h_we, h_lock, h_gnt, h_rvalid, h_err;
    logic [31:0] h_addr, h_wdata, h_rdata;
    logic        mem_en, mem_we;
    logic [5:0]  mem_idx;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] mem [64];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.IDX_W(6), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_lock(h_lock),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_err(h_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory contents are reloaded on every reset so each test starts from known data.
    always @(posedge clk) begin
        if (rst) begin
            mem[0]    <= 32'h0000_1234;
            mem[1]    <= 32'h0000_0000;
            mem[2]    <= 32'hDEAD_BEEF;
            mem_rdata <= 32'hA5A5_A5A5;
        end else begin
            if (mem_en && mem_we)  mem[mem_idx] <= mem_wdata;
            if (mem_en && !mem_we) mem_rdata    <= mem[mem_idx];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0; h_lock = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
        cyc();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; c_req = 1; h_req = 1; h_addr = 32'h4;
        @(negedge clk);
        n_cmp++; if (c_gnt !== 1'b0)     begin n_err++; $display("FAIL rst_c_gnt got %b want 0", c_gnt); end
        n_cmp++; if (h_gnt !== 1'b0)     begin n_err++; $display("FAIL rst_h_gnt got %b want 0", h_gnt); end
        n_cmp++; if (mem_en !== 1'b0)    begin n_err++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
        n_cmp++; if (c_rvalid !== 1'b0)  begin n_err++; $display("FAIL rst_c_rvalid got %b want 0", c_rvalid); end
        n_cmp++; if (h_err !== 1'b0)     begin n_err++; $display("FAIL rst_h_err got %b want 0", h_err); end
        n_cmp++; if (c_rdata !== 32'd0)  begin n_err++; $display("FAIL rst_c_rdata got %h want 0", c_rdata); end
        cyc();
        cyc();
        rst = 0;
        @(negedge clk);
        n_cmp++; if (c_gnt !== 1'b0)     begin n_err++; $display("FAIL rst_after_c_gnt got %b want 0", c_gnt); end
        n_cmp++; if (h_gnt !== 1'b0)     begin n_err++; $display("FAIL rst_after_h_gnt got %b want 0", h_gnt); end
        n_cmp++; if (mem_we !== 1'b0)    begin n_err++; $display("FAIL rst_after_mem_we got %b want 0", mem_we); end
        cyc();
        @(negedge clk);
        n_cmp++; if (c_gnt !== 1'b1)     begin n_err++; $display("FAIL rst_first_tie_core got %b want 1", c_gnt); end
        n_cmp++; if (h_gnt !== 1'b0)     begin n_err++; $display("FAIL rst_first_tie_host got %b want 0", h_gnt); end
        cyc();
        clear_inputs();
    endtask

    task automatic test_read();
        do_reset();
        c_req = 1; c_we = 0; c_addr = 32'h8;
        @(negedge clk);
        n_cmp++; if (c_gnt !== 1'b1)     begin n_err++; $display("FAIL rd_gnt got %b want 1", c_gnt); end
        n_cmp++; if (mem_en !== 1'b1)    begin n_err++; $display("FAIL rd_mem_en got %b want 1", mem_en); end
        n_cmp++; if (mem_we !== 1'b0)    begin n_err++; $display("FAIL rd_mem_we got %b want 0", mem_we); end
        n_cmp++; if (mem_idx !== 6'd2)   begin n_err++; $display("FAIL rd_idx got %0d want 2", mem_idx); end
        n_cmp++; if (c_rvalid !== 1'b0)  begin n_err++; $display("FAIL rd_early_rvalid got %b want 0", c_rvalid); end
        cyc();
        c_req = 0;
        @(negedge clk);
        n_cmp++; if (c_rvalid !== 1'b1)  begin n_err++; $display("FAIL rd_rvalid got %b want 1", c_rvalid); end
        n_cmp++; if (c_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata got %h want deadbeef", c_rdata); end
        n_cmp++; if (c_err !== 1'b0)     begin n_err++; $display("FAIL rd_err got %b want 0", c_err); end
        n_cmp++; if (h_rvalid !== 1'b0)  begin n_err++; $display("FAIL rd_h_rvalid got %b want 0", h_rvalid); end
        cyc();
    endtask

    task automatic test_round_robin();
        logic exp_c [4];
        exp_c = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        c_req = 1; c_addr = 32'h0; h_req = 1; h_addr = 32'h4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (c_gnt !== exp_c[i])    begin n_err++; $display("FAIL rr_c_gnt[%0d] got %b want %b", i, c_gnt, exp_c[i]); end
            n_cmp++; if (h_gnt !== !exp_c[i])   begin n_err++; $display("FAIL rr_h_gnt[%0d] got %b want %b", i, h_gnt, !exp_c[i]); end
            n_cmp++; if (c_stall !== !exp_c[i]) begin n_err++; $display("FAIL rr_stall[%0d] got %b want %b", i, c_stall, !exp_c[i]); end
            cyc();
        end
        clear_inputs();
        @(negedge clk);
        n_cmp++; if (c_stall !== 1'b0)   begin n_err++; $display("FAIL rr_idle_stall got %b want 0", c_stall); end
        cyc();
    endtask

    task automatic test_lock();
        logic exp_h [6];
        exp_h = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        c_req = 1; c_addr = 32'h0;
        @(negedge clk);
        n_cmp++; if (c_gnt !== 1'b1)     begin n_err++; $display("FAIL lock_pre_core got %b want 1", c_gnt); end
        cyc();
        h_req = 1; h_lock = 1; h_addr = 32'h4;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++; if (h_gnt !== exp_h[i])  begin n_err++; $display("FAIL lock_h_gnt[%0d] got %b want %b", i, h_gnt, exp_h[i]); end
            n_cmp++; if (c_gnt !== !exp_h[i]) begin n_err++; $display("FAIL lock_c_gnt[%0d] got %b want %b", i, c_gnt, !exp_h[i]); end
            cyc();
        end
        clear_inputs();
        cyc();
    endtask

    task automatic test_bad_addr();
        do_reset();
        h_req = 1; h_we = 1; h_addr = 32'h102; h_wdata = 32'h0000_0BAD;
        @(negedge clk);
        n_cmp++; if (h_gnt !== 1'b1)     begin n_err++; $display("FAIL bad_h_gnt got %b want 1", h_gnt); end
        n_cmp++; if (mem_en !== 1'b0)    begin n_err++; $display("FAIL bad_wr_mem_en got %b want 0", mem_en); end
        cyc();
        h_req = 0; h_we = 0;
        c_req = 1; c_we = 0; c_addr = 32'h100;
        @(negedge clk);
        n_cmp++; if (h_err !== 1'b1)     begin n_err++; $display("FAIL bad_h_err got %b want 1", h_err); end
        n_cmp++; if (h_rvalid !== 1'b0)  begin n_err++; $display("FAIL bad_h_rvalid got %b want 0", h_rvalid); end
        n_cmp++; if (c_gnt !== 1'b1)     begin n_err++; $display("FAIL bad_c_gnt got %b want 1", c_gnt); end
        n_cmp++; if (mem_en !== 1'b0)    begin n_err++; $display("FAIL bad_rd_mem_en got %b want 0", mem_en); end
        cyc();
        c_req = 0;
        @(negedge clk);
        n_cmp++; if (c_rvalid !== 1'b1)  begin n_err++; $display("FAIL bad_c_rvalid got %b want 1", c_rvalid); end
        n_cmp++; if (c_err !== 1'b1)     begin n_err++; $display("FAIL bad_c_err got %b want 1", c_err); end
        n_cmp++; if (c_rdata !== 32'd0)  begin n_err++; $display("FAIL bad_c_rdata got %h want 0", c_rdata); end
        n_cmp++; if (h_err !== 1'b0)     begin n_err++; $display("FAIL bad_h_err_clear got %b want 0", h_err); end
        n_cmp++; if (mem[0] !== 32'h0000_1234) begin n_err++; $display("FAIL bad_mem_untouched got %h want 00001234", mem[0]); end
        cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        c_req = 1; c_we = 0; c_addr = 32'h8;
        @(negedge clk);
        n_cmp++; if (c_gnt !== 1'b1)     begin n_err++; $display("FAIL mid_gnt got %b want 1", c_gnt); end
        cyc();
        c_req = 0; rst = 1;
        @(negedge clk);
        n_cmp++; if (c_rvalid !== 1'b0)  begin n_err++; $display("FAIL mid_rvalid_in_rst got %b want 0", c_rvalid); end
        n_cmp++; if (c_rdata !== 32'd0)  begin n_err++; $display("FAIL mid_rdata_in_rst got %h want 0", c_rdata); end
        cyc();
        rst = 0;
        @(negedge clk);
        n_cmp++; if (c_rvalid !== 1'b0)  begin n_err++; $display("FAIL mid_rvalid_after got %b want 0", c_rvalid); end
        n_cmp++; if (c_err !== 1'b0)     begin n_err++; $display("FAIL mid_err_after got %b want 0", c_err); end
        n_cmp++; if (mem_en !== 1'b0)    begin n_err++; $display("FAIL mid_mem_en_after got %b want 0", mem_en); end
        cyc();
        // Take the lock, reset while it is held, then check the core wins the first tie.
        h_req = 1; h_lock = 1; h_addr = 32'h4;
        @(negedge clk);
        n_cmp++; if (h_gnt !== 1'b1)     begin n_err++; $display("FAIL mid_lock_take got %b want 1", h_gnt); end
        cyc();
        rst = 1;
        cyc();
        rst = 0;
        cyc();
        c_req = 1; c_addr = 32'h0;
        @(negedge clk);
        n_cmp++; if (c_gnt !== 1'b1)     begin n_err++; $display("FAIL mid_lock_released got %b want 1", c_gnt); end
        n_cmp++; if (h_gnt !== 1'b0)     begin n_err++; $display("FAIL mid_lock_host got %b want 0", h_gnt); end
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_back_to_back();
        do_reset();
        c_req = 1; c_we = 1; c_addr = 32'h4; c_wdata = 32'h55;
        @(negedge clk);
        n_cmp++; if (c_gnt !== 1'b1)     begin n_err++; $display("FAIL b2b_wr_gnt got %b want 1", c_gnt); end
        n_cmp++; if (mem_we !== 1'b1)    begin n_err++; $display("FAIL b2b_mem_we got %b want 1", mem_we); end
        n_cmp++; if (c_stall !== 1'b0)   begin n_err++; $display("FAIL b2b_stall0 got %b want 0", c_stall); end
        cyc();
        c_we = 0;
        @(negedge clk);
        n_cmp++; if (c_gnt !== 1'b1)     begin n_err++; $display("FAIL b2b_rd_gnt got %b want 1", c_gnt); end
        n_cmp++; if (c_rvalid !== 1'b0)  begin n_err++; $display("FAIL b2b_wr_no_rvalid got %b want 0", c_rvalid); end
        n_cmp++; if (c_err !== 1'b0)     begin n_err++; $display("FAIL b2b_wr_err got %b want 0", c_err); end
        n_cmp++; if (c_stall !== 1'b0)   begin n_err++; $display("FAIL b2b_stall1 got %b want 0", c_stall); end
        cyc();
        c_addr = 32'h8;
        @(negedge clk);
        n_cmp++; if (c_rvalid !== 1'b1)  begin n_err++; $display("FAIL b2b_rvalid0 got %b want 1", c_rvalid); end
        n_cmp++; if (c_rdata !== 32'h55) begin n_err++; $display("FAIL b2b_rdata0 got %h want 00000055", c_rdata); end
        n_cmp++; if (c_stall !== 1'b0)   begin n_err++; $display("FAIL b2b_stall2 got %b want 0", c_stall); end
        cyc();
        c_req = 0;
        @(negedge clk);
        n_cmp++; if (c_rvalid !== 1'b1)  begin n_err++; $display("FAIL b2b_rvalid1 got %b want 1", c_rvalid); end
        n_cmp++; if (c_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL b2b_rdata1 got %h want deadbeef", c_rdata); end
        cyc();
        @(negedge clk);
        n_cmp++; if (c_rvalid !== 1'b0)  begin n_err++; $display("FAIL b2b_rvalid_end got %b want 0", c_rvalid); end
        cyc();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_read();
        test_round_robin();
        test_lock();
        test_bad_addr();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
